// File: rtl/data_mem_mmio.sv
// -----------------------------------------------------------------------------
// data_mem_mmio
//   Data-memory responder for the single-cycle core. A word RAM sits at the
//   bottom of the address space and a four-register MMIO page sits at
//   MMIO_BASE: an LED register, a free-running 64-bit cycle counter split
//   into LO/HI words, and a console TX byte FIFO that drains through a
//   valid/ready stream. Loads are combinational; stores commit at the next
//   rising edge.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   Addr       byte address from the core (bits [1:0] ignored)
//   MemWrite   store strobe
//   WriteData  store data
//   ReadData   load data, combinational from Addr
//   led        LED register
//   tx_data    TX FIFO head byte
//   tx_valid   TX FIFO not empty
//   tx_ready   sink accepts tx_data when tx_valid & tx_ready at an edge
//   bus_err    sticky flag, set by any access to an unmapped address
// -----------------------------------------------------------------------------
module data_mem_mmio #(
    parameter int          RAM_WORDS  = 256,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        MemWrite,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int               RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [29:0]      RAM_LIMIT = 30'(RAM_WORDS);
    localparam logic [29:0]      MMIO_WORD = MMIO_BASE[31:2];
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    logic [31:0]      ram [RAM_WORDS];
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [63:0]      cycle_cnt;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             ovf;

    logic [29:0]      word_addr;
    logic [RAM_AW-1:0] ram_idx;
    logic             ram_sel;
    logic             led_sel;
    logic             lo_sel;
    logic             hi_sel;
    logic             tx_sel;
    logic             unmapped;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             accept;
    logic             unused_addr_bits;

    // Word-granular decode; the byte offset bits play no part in it.
    assign word_addr        = Addr[31:2];
    assign unused_addr_bits = ^Addr[1:0];
    assign ram_idx          = Addr[RAM_AW+1:2];

    assign ram_sel  = (word_addr < RAM_LIMIT);
    assign led_sel  = (word_addr == MMIO_WORD);
    assign lo_sel   = (word_addr == MMIO_WORD + 30'd1);
    assign hi_sel   = (word_addr == MMIO_WORD + 30'd2);
    assign tx_sel   = (word_addr == MMIO_WORD + 30'd3);
    assign unmapped = ~(ram_sel | led_sel | lo_sel | hi_sel | tx_sel);

    assign fifo_full  = (fifo_count == FULL_CNT);
    assign fifo_empty = (fifo_count == '0);
    assign tx_valid   = ~fifo_empty;
    assign tx_data    = fifo_mem[rd_ptr];

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign pop    = tx_valid & tx_ready;
    assign push   = MemWrite & tx_sel & ~reset;
    assign accept = push & (~fifo_full | pop);

    // Load mux: every register is readable, unmapped addresses return zero.
    always_comb begin
        ReadData = '0;
        if (ram_sel)
            ReadData = ram[ram_idx];
        else if (led_sel)
            ReadData = {24'b0, led};
        else if (lo_sel)
            ReadData = cycle_cnt[31:0];
        else if (hi_sel)
            ReadData = cycle_cnt[63:32];
        else if (tx_sel)
            ReadData = {29'b0, ovf, fifo_full, fifo_empty};
    end

    // RAM contents survive reset; only the store path is gated by it.
    always_ff @(posedge clk) begin
        if (MemWrite && ram_sel && !reset)
            ram[ram_idx] <= WriteData;
    end

    always_ff @(posedge clk) begin
        if (accept)
            fifo_mem[wr_ptr] <= WriteData[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led       <= '0;
            cycle_cnt <= '0;
            bus_err   <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (MemWrite && led_sel)
                led <= WriteData[7:0];
            // The address is presented every cycle, so any unmapped address
            // counts as an access, store or not.
            if (unmapped)
                bus_err <= 1'b1;
        end
    end

    // FIFO bookkeeping; pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            ovf        <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (accept && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !accept)
                fifo_count <= fifo_count - 1'b1;
            if (push && !accept)
                ovf <= 1'b1;
        end
    end

endmodule
